// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle ops and an iterative shift-add MUL.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake for A, B, Control_Input
//   out_valid / out_ready : output handshake for ALU_Result, Result_Hi, flags
//   ALU_Result, Result_Hi : result (MUL low/high halves; Hi is 0 otherwise)
//   Zero/Neg/Carry/Ovf    : flags registered together with the result
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Control_Input,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Result,
    output logic [WIDTH-1:0] Result_Hi,
    output logic             Zero_Flag,
    output logic             Neg_Flag,
    output logic             Carry_Flag,
    output logic             Ovf_Flag
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   r_mplier;
    logic [SHW-1:0]     r_cnt;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_hi;
    logic               r_z;
    logic               r_n;
    logic               r_c;
    logic               r_v;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_last;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [SHW-1:0]     w_sh;

    assign w_accept  = in_valid & in_ready;
    assign w_is_mul  = (Control_Input == 3'b011);
    assign w_last    = (r_cnt == SHW'(WIDTH - 1));
    assign w_sh      = B[SHW-1:0];
    assign w_add     = {1'b0, A} + {1'b0, B};
    // Top bit of the widened difference is the unsigned borrow (A < B).
    assign w_sub     = {1'b0, A} - {1'b0, B};
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        unique case (Control_Input)
            3'b000: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (A[WIDTH-1] == B[WIDTH-1]) &&
                        (w_add[WIDTH-1] != A[WIDTH-1]);
            end
            3'b111: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (A[WIDTH-1] != B[WIDTH-1]) &&
                        (w_sub[WIDTH-1] != A[WIDTH-1]);
            end
            3'b001: w_res = A ^ B;
            3'b100: w_res = A | B;
            3'b010: w_res = A << w_sh;
            3'b101: w_res = A >> w_sh;
            3'b110: w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            3'b011: w_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
                end else if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_BUSY:  in_ready = 1'b0;
            S_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath: result/flag registers and the shift-add multiplier
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_hi     <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_mcand  <= {{WIDTH{1'b0}}, A};
                r_mplier <= B;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else begin
                r_res <= w_res;
                r_hi  <= '0;
                r_z   <= (w_res == '0);
                r_n   <= w_res[WIDTH-1];
                r_c   <= w_c;
                r_v   <= w_v;
            end
        end else if (r_state == S_BUSY) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_res <= w_acc_nxt[WIDTH-1:0];
                r_hi  <= w_acc_nxt[2*WIDTH-1:WIDTH];
                r_z   <= (w_acc_nxt[WIDTH-1:0] == '0);
                r_n   <= w_acc_nxt[WIDTH-1];
                r_c   <= 1'b0;
                r_v   <= (w_acc_nxt[2*WIDTH-1:WIDTH] != '0);
            end
        end
    end

    assign ALU_Result = r_res;
    assign Result_Hi  = r_hi;
    assign Zero_Flag  = r_z;
    assign Neg_Flag   = r_n;
    assign Carry_Flag = r_c;
    assign Ovf_Flag   = r_v;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq at WIDTH=32, plus a WIDTH=8 MUL check.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, res, hi;
    logic [2:0]  op;
    logic        zf, nf, cf, vf;

    logic        v8_in, r8_in, v8_out, r8_out;
    logic [7:0]  a8, b8, res8, hi8;
    logic [2:0]  op8;
    logic        z8, n8, c8, o8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  f;
    } vec_t;

    vec_t vt[12];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Control_Input(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_Result(res), .Result_Hi(hi),
        .Zero_Flag(zf), .Neg_Flag(nf), .Carry_Flag(cf), .Ovf_Flag(vf)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(v8_in), .in_ready(r8_in),
        .A(a8), .B(b8), .Control_Input(op8),
        .out_valid(v8_out), .out_ready(r8_out),
        .ALU_Result(res8), .Result_Hi(hi8),
        .Zero_Flag(z8), .Neg_Flag(n8), .Carry_Flag(c8), .Ovf_Flag(o8)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
        in_valid = 1'b1;
        op       = o;
        A        = a;
        B        = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int lat;

        vt[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010};
        vt[1]  = '{3'b111, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001};
        vt[2]  = '{3'b111, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0110};
        vt[3]  = '{3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000};
        vt[4]  = '{3'b100, 32'h12340000, 32'h00005678, 32'h12345678, 4'b0000};
        vt[5]  = '{3'b010, 32'h00000001, 32'h00000025, 32'h00000020, 4'b0000};
        vt[6]  = '{3'b101, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000};
        vt[7]  = '{3'b110, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 4'b0000};
        vt[8]  = '{3'b110, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 4'b1000};
        vt[9]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101};
        vt[10] = '{3'b001, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 4'b1000};
        vt[11] = '{3'b111, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1000};

        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; op = '0;
        v8_in = 1'b0; r8_out = 1'b1; a8 = '0; b8 = '0; op8 = '0;
        step();
        step();
        reset = 1'b0;

        chk("rst_hs", 64'({out_valid, in_ready}), 64'(2'b01));
        chk("rst_res", 64'({res, hi}), 64'd0);
        chk("rst_flags", 64'({zf, nf, cf, vf}), 64'd0);

        // Back-to-back single-cycle ops, one accepted per cycle
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            drv(vt[i].op, vt[i].a, vt[i].b);
            step();
            if (in_ready !== 1'b1) bad++;
            chk($sformatf("vec%0d_res", i), 64'(res), 64'(vt[i].res));
            chk($sformatf("vec%0d_hi", i), 64'(hi), 64'd0);
            chk($sformatf("vec%0d_flags", i),
                64'({out_valid, zf, nf, cf, vf}), 64'({1'b1, vt[i].f}));
        end
        chk("b2b_in_ready", 64'(bad), 64'd0);
        in_valid = 1'b0;
        step();
        chk("b2b_drain", 64'(out_valid), 64'd0);

        // MUL 0xFFFFFFFF^2: busy 32 cycles, result in cycle N+33
        drv(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step();
        in_valid = 1'b0;
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            step();
        end
        chk("mul_busy", 64'(bad), 64'd0);
        chk("mul_valid", 64'(out_valid), 64'd1);
        chk("mul_prod", {hi, res}, 64'hFFFFFFFE_00000001);
        chk("mul_flags", 64'({zf, nf, cf, vf}), 64'(4'b0001));
        step();
        chk("mul_drain", 64'(out_valid), 64'd0);

        // Backpressure: ADD 2+3 held while out_ready=0
        out_ready = 1'b0;
        drv(3'b000, 32'd2, 32'd3);
        step();
        drv(3'b111, 32'd9, 32'd1);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid !== 1'b1 || res !== 32'd5 || in_ready !== 1'b0) bad++;
            step();
        end
        chk("bp_hold", 64'(bad), 64'd0);
        chk("bp_res_still", 64'(res), 64'd5);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        step();
        chk("bp_next_res", 64'(res), 64'd8);
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        step();
        chk("bp_drain", 64'(out_valid), 64'd0);

        // Reset in cycle N+10 of a MUL
        drv(3'b011, 32'h00012345, 32'h00000777);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_hs", 64'({out_valid, in_ready}), 64'(2'b01));
        chk("mrst_res", 64'({res, hi}), 64'd0);
        chk("mrst_flags", 64'({zf, nf, cf, vf}), 64'd0);

        drv(3'b011, 32'd7, 32'd6);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk("mul76_latency", 64'(lat), 64'd33);
        chk("mul76_prod", {hi, res}, 64'd42);
        chk("mul76_flags", 64'({zf, nf, cf, vf}), 64'd0);
        step();

        // WIDTH=8: MUL 0xFF*0x02 with latency 9, then SLL ignoring high B bits
        v8_in = 1'b1; op8 = 3'b011; a8 = 8'hFF; b8 = 8'h02;
        step();
        v8_in = 1'b0;
        lat = 1;
        while (v8_out !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk("w8_latency", 64'(lat), 64'd9);
        chk("w8_prod", 64'({hi8, res8}), 64'h01FE);
        chk("w8_flags", 64'({z8, n8, c8, o8}), 64'(4'b0101));
        v8_in = 1'b1; op8 = 3'b010; a8 = 8'h01; b8 = 8'h0B;
        step();
        v8_in = 1'b0;
        chk("w8_sll", 64'({v8_out, hi8, res8}), 64'({1'b1, 8'h00, 8'h08}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU. Same 3-bit operation encoding, extended with SRL and SLT.
- Single-cycle ops return one cycle after accept; MUL is an iterative shift-add unit taking WIDTH+1 cycles and returning the full 2*WIDTH product.
- Adds a full flag set (zero, negative, carry, overflow) and valid/ready flow control on both sides, for use in the EX stage with stall support.

Parameters:
WIDTH  32  operand/result width; power of 2, >= 4
SHW  $clog2(WIDTH)  shift-amount width (derived, not overridable)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands/op valid
in_ready  output  1  block can accept this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
Control_Input  input  3  operation select
out_valid  output  1  result valid
out_ready  input  1  consumer takes result this cycle
ALU_Result  output  WIDTH  result (MUL: low half of product)
Result_Hi  output  WIDTH  MUL high half of product; 0 for other ops
Zero_Flag  output  1  ALU_Result == 0
Neg_Flag  output  1  ALU_Result[WIDTH-1]
Carry_Flag  output  1  ADD carry-out; SUB borrow (A<B unsigned); else 0
Ovf_Flag  output  1  ADD/SUB signed overflow; MUL: Result_Hi != 0; else 0

Behaviour:
- Clocking and reset: one clock (clk). reset is synchronous, active-high, sampled on the rising edge.
- Reset effect: state=IDLE, out_valid=0, ALU_Result=0, Result_Hi=0, all flags=0, iteration counter=0. Takes priority over every other event, including mid-MUL (the partial product is discarded).
- Opcodes:
  - 000 ADD, 001 XOR, 100 OR, 111 SUB (A-B), 010 SLL (A<<B[SHW-1:0]): single-cycle.
  - 101 SRL (logical A>>B[SHW-1:0]): single-cycle.
  - 110 SLT (signed A<B → 1, else 0): single-cycle.
  - 011 MUL (unsigned A*B): iterative.
  - B bits above SHW are ignored for shifts.
- States:
  - IDLE: nothing held.
  - BUSY: MUL iterating.
  - DONE: result held, out_valid=1.
- Handshake:
  - Accept occurs when in_valid & in_ready at a rising edge.
  - in_ready = (state==IDLE) | (state==DONE & out_ready). It is 0 throughout BUSY.
  - Result is consumed when out_valid & out_ready.
  - Outputs and flags stay stable while out_valid=1 and out_ready=0.
- Transitions:
  - IDLE, accept, single-cycle op → DONE. Result and flags registered at the accept edge.
  - IDLE, accept, MUL → BUSY. Operands latched, product accumulator=0, counter=0.
  - BUSY: each edge processes one multiplier bit (LSB first, shift-add) and increments the counter. On the edge processing bit WIDTH-1 → DONE with the full 2*WIDTH product and flags.
  - DONE, consume, no accept → IDLE; out_valid=0 next cycle.
  - DONE, consume and accept in same cycle → DONE (single-cycle op) or BUSY (MUL), as from IDLE. This gives back-to-back throughput of 1 op/cycle for single-cycle ops.
  - DONE, no consume → hold.
- Latency (accept in cycle N):
  - Single-cycle op: out_valid in cycle N+1.
  - MUL: BUSY during cycles N+1..N+WIDTH; out_valid in cycle N+WIDTH+1.
- Flags are computed from the registered result. Zero_Flag looks at ALU_Result only, never Result_Hi.
- Signed overflow:
  - ADD: A,B same sign and result sign differs.
  - SUB: A,B signs differ and result sign differs from A.
- in_valid with in_ready=0 has no effect; the upstream must hold its inputs.

Test Plan:
- reset, then ADD A=0xFFFFFFFF B=1 (WIDTH=32) → next cycle out_valid=1, ALU_Result=0, Zero=1, Carry=1, Ovf=0, Neg=0.
- SUB A=0x80000000 B=1 → Result=0x7FFFFFFF, Ovf=1, Carry=0. Then SUB A=3 B=5 → Result=0xFFFFFFFE, Carry=1, Neg=1.
- MUL A=0xFFFFFFFF B=0xFFFFFFFF, out_ready=1:
  - in_ready=0 for 32 cycles; out_valid exactly in cycle N+33.
  - Result_Hi=0xFFFFFFFE, ALU_Result=0x00000001, Ovf=1.
- Back-to-back: XOR, OR, SLL(A=1,B=0x25 → shift 5 → 0x20), SRL(A=0x80000000,B=31 → 1), SLT(A=-1,B=0 → 1) on consecutive cycles with out_ready=1 → one result per cycle, in order, none dropped.
- Backpressure: ADD 2+3 with out_ready=0 for 4 cycles → Result=5 held stable, in_ready=0; a new in_valid is not accepted until the cycle out_ready=1.
- reset asserted in cycle N+10 of a MUL → next cycle state IDLE, out_valid=0, outputs 0. A subsequent MUL 7*6 → ALU_Result=42, Result_Hi=0. Repeat the MUL at WIDTH=8: 0xFF*0x02 → Hi=0x01, Lo=0xFE, latency 9.
